// File: rtl/vision_pkg.sv
// Shared definitions for vision stimulus and detection blocks: the pattern
// generator FSM state encoding and default luma levels.
package vision_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } zebra_state_e;

  localparam logic [7:0] DEF_WHITE_LEVEL = 8'd255;
  localparam logic [7:0] DEF_BLACK_LEVEL = 8'd16;

  // Band counter width; it saturates at all-ones, which is above any legal
  // 2*stripes (max 30), so saturation never turns a gap into a stripe.
  localparam int BAND_W = 5;

endpackage

// File: rtl/zebra_pattern_gen.sv
// Zebra stripe test-pattern source. Streams one raster frame of
// IMG_WIDTH x IMG_HEIGHT pixels. Horizontal white stripes of stripe_h rows,
// separated by equal-height gaps, start at row y_top and are limited to the
// column window [x_lo, x_hi]. Everything else is BLACK_LEVEL.
//
// Handshake: a beat transfers on a rising clk edge where y_valid && y_ready.
// y_valid, once raised, stays high until that beat transfers, and y_data,
// y_sof and y_eol are held unchanged while y_valid && !y_ready. Within a
// frame y_valid never drops; it is low for exactly one cycle after the
// last beat of each frame.
module zebra_pattern_gen
  import vision_pkg::*;
#(
  parameter int             IMG_WIDTH   = 320,
  parameter int             IMG_HEIGHT  = 240,
  parameter int             W           = 8,
  parameter logic [W-1:0]   WHITE_LEVEL = W'(DEF_WHITE_LEVEL),
  parameter logic [W-1:0]   BLACK_LEVEL = W'(DEF_BLACK_LEVEL)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          cfg_continuous,
  input  logic [$clog2(IMG_HEIGHT)-1:0] cfg_y_top,
  input  logic [7:0]                    cfg_stripe_h,
  input  logic [3:0]                    cfg_stripes,
  input  logic [$clog2(IMG_WIDTH)-1:0]  cfg_x_lo,
  input  logic [$clog2(IMG_WIDTH)-1:0]  cfg_x_hi,
  output logic                          y_valid,
  input  logic                          y_ready,
  output logic [W-1:0]                  y_data,
  output logic                          y_sof,
  output logic                          y_eol,
  output logic                          busy,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic [1:0]                    dbg_state
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  zebra_state_e state_q;

  // Coordinates and band tracking of the pixel currently presented.
  logic [XW-1:0]     x_q, n_x;
  logic [YW-1:0]     y_q, n_y;
  logic              in_q, n_in;       // row is at or below y_top
  logic [7:0]        rib_q, n_rib;     // row index inside current band
  logic [BAND_W-1:0] band_q, n_band;   // band index, saturating

  // Configuration latched at frame start.
  logic          cont_q;
  logic [YW-1:0] y_top_q;
  logic [7:0]    sh_q;                 // never zero: 0 is stored as 1
  logic [3:0]    stripes_q;
  logic [XW-1:0] x_lo_q, x_hi_q;

  // Window/stripe-count source for the next pixel: fresh inputs on a load.
  logic [3:0]    stripes_s;
  logic [XW-1:0] x_lo_s, x_hi_s;

  logic hs, last, load, fin, adv, n_white;

  assign hs   = y_valid && y_ready;
  assign last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign load = ((state_q == ST_IDLE) && start) || ((state_q == ST_DONE) && cont_q);
  assign fin  = (state_q == ST_STREAM) && hs && last;
  assign adv  = load || ((state_q == ST_STREAM) && hs && !last);

  assign stripes_s = load ? cfg_stripes : stripes_q;
  assign x_lo_s    = load ? cfg_x_lo    : x_lo_q;
  assign x_hi_s    = load ? cfg_x_hi    : x_hi_q;

  assign dbg_state = state_q;

  // Next pixel position and band state: frame origin on a load, else the
  // raster successor. Bands advance with a row-in-band counter, no divider.
  always_comb begin
    n_x    = x_q;
    n_y    = y_q;
    n_in   = in_q;
    n_rib  = rib_q;
    n_band = band_q;
    if (load) begin
      n_x    = '0;
      n_y    = '0;
      n_in   = (cfg_y_top == '0);
      n_rib  = '0;
      n_band = '0;
    end else if (x_q == X_LAST) begin
      n_x = '0;
      n_y = y_q + YW'(1);
      if (n_y == y_top_q) begin
        n_in   = 1'b1;
        n_rib  = '0;
        n_band = '0;
      end else if (in_q) begin
        if (rib_q == sh_q - 8'd1) begin
          n_rib = '0;
          if (band_q != '1) n_band = band_q + BAND_W'(1);
        end else begin
          n_rib = rib_q + 8'd1;
        end
      end
    end else begin
      n_x = x_q + XW'(1);
    end
  end

  // Stripe decision for the next pixel: even band, below the stripe limit,
  // inside the column window. An empty window (x_lo > x_hi) never matches.
  always_comb begin
    n_white = n_in && !n_band[0] && (n_band < {stripes_s, 1'b0}) &&
              (n_x >= x_lo_s) && (n_x <= x_hi_s);
  end

  // Frame control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      y_valid     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_STREAM;
            y_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (fin) begin
            state_q     <= ST_DONE;
            y_valid     <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
        end
        ST_DONE: begin
          if (cont_q) begin
            state_q <= ST_STREAM;
            y_valid <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          y_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Pixel datapath: latch config on load, step the raster on each accepted
  // beat, park the output at black once the frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      in_q      <= 1'b0;
      rib_q     <= '0;
      band_q    <= '0;
      cont_q    <= 1'b0;
      y_top_q   <= '0;
      sh_q      <= 8'd1;
      stripes_q <= '0;
      x_lo_q    <= '0;
      x_hi_q    <= '0;
      y_data    <= BLACK_LEVEL;
      y_sof     <= 1'b0;
      y_eol     <= 1'b0;
    end else begin
      if (load) begin
        cont_q    <= cfg_continuous;
        y_top_q   <= cfg_y_top;
        sh_q      <= (cfg_stripe_h == 8'd0) ? 8'd1 : cfg_stripe_h;
        stripes_q <= cfg_stripes;
        x_lo_q    <= cfg_x_lo;
        x_hi_q    <= cfg_x_hi;
      end
      if (adv) begin
        x_q    <= n_x;
        y_q    <= n_y;
        in_q   <= n_in;
        rib_q  <= n_rib;
        band_q <= n_band;
        y_data <= n_white ? WHITE_LEVEL : BLACK_LEVEL;
        y_sof  <= (n_x == '0) && (n_y == '0);
        y_eol  <= (n_x == X_LAST);
      end else if (fin) begin
        y_data <= BLACK_LEVEL;
        y_sof  <= 1'b0;
        y_eol  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zebra_pattern_gen.sv
// Directed bench for zebra_pattern_gen on a reduced 40x30 raster so several
// full frames fit in a short run. Expected pixels come from a divider-based
// reference formula; white-pixel totals are hand-computed constants.
module tb_zebra_pattern_gen;
  import vision_pkg::*;

  localparam int IW   = 40;
  localparam int IH   = 30;
  localparam int NPIX = IW * IH;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start, cfg_continuous, y_ready;
  logic [4:0] cfg_y_top;
  logic [7:0] cfg_stripe_h;
  logic [3:0] cfg_stripes;
  logic [5:0] cfg_x_lo, cfg_x_hi;
  logic       y_valid, y_sof, y_eol, busy, frame_done;
  logic [7:0] y_data;
  logic [15:0] frame_count;
  logic [1:0] dbg_state;

  zebra_pattern_gen #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_continuous(cfg_continuous),
    .cfg_y_top(cfg_y_top), .cfg_stripe_h(cfg_stripe_h), .cfg_stripes(cfg_stripes),
    .cfg_x_lo(cfg_x_lo), .cfg_x_hi(cfg_x_hi), .y_valid(y_valid), .y_ready(y_ready),
    .y_data(y_data), .y_sof(y_sof), .y_eol(y_eol), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard storage
  logic [7:0] exp_q[$];
  logic [7:0] pix_q[$];
  bit         sof_q[$];
  bit         eol_q[$];
  int         cyc_q[$];
  int         stall_err;
  int         done_cnt = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && frame_done) done_cnt++;

  function automatic logic [7:0] model_pix(int x, int y, int ytop, int sh, int st, int xlo, int xhi);
    int she, band;
    she = (sh == 0) ? 1 : sh;
    if (x < xlo || x > xhi || y < ytop) return 8'd16;
    band = (y - ytop) / she;
    if ((band % 2) == 0 && band < 2 * st) return 8'd255;
    return 8'd16;
  endfunction

  task automatic build_exp(input int ytop, input int sh, input int st, input int xlo,
                           input int xhi, input int frames);
    exp_q.delete();
    for (int f = 0; f < frames; f++)
      for (int y = 0; y < IH; y++)
        for (int x = 0; x < IW; x++)
          exp_q.push_back(model_pix(x, y, ytop, sh, st, xlo, xhi));
  endtask

  function automatic int pix_mismatches();
    int m = 0;
    if (pix_q.size() != exp_q.size()) return -1;
    foreach (pix_q[k]) if (pix_q[k] !== exp_q[k]) m++;
    return m;
  endfunction

  function automatic int white_count();
    int w = 0;
    foreach (pix_q[k]) if (pix_q[k] == 8'd255) w++;
    return w;
  endfunction

  // Beats where sof/eol disagree with raster position
  function automatic int marker_errors();
    int e = 0;
    foreach (pix_q[k]) begin
      if (sof_q[k] != ((k % NPIX) == 0)) e++;
      if (eol_q[k] != ((k % IW) == IW - 1)) e++;
    end
    return e;
  endfunction

  // Beats whose spacing differs from 1 cycle (2 cycles at a frame boundary)
  function automatic int spacing_errors();
    int e = 0;
    for (int k = 1; k < cyc_q.size(); k++)
      if ((cyc_q[k] - cyc_q[k-1]) != (((k % NPIX) == 0) ? 2 : 1)) e++;
    return e;
  endfunction

  // Driver tasks
  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; cfg_continuous = 1'b0; y_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_cnt = 0;
  endtask

  task automatic set_cfg(input int ytop, input int sh, input int st, input int xlo, input int xhi);
    cfg_y_top = 5'(ytop); cfg_stripe_h = 8'(sh); cfg_stripes = 4'(st);
    cfg_x_lo = 6'(xlo); cfg_x_hi = 6'(xhi);
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Collect n accepted beats starting at the current negedge; ready is
  // randomised per cycle and every stalled cycle is checked for stability.
  task automatic collect(input int n, input int stall_pct, input int drop_cont_at,
                         output bit timed_out);
    bit pv = 0, pr = 0, ps = 0, pe = 0;
    logic [7:0] pd = '0;
    int budget = n * 5 + 50;
    pix_q.delete(); sof_q.delete(); eol_q.delete(); cyc_q.delete();
    stall_err = 0;
    for (int c = 0; c < budget && pix_q.size() < n; c++) begin
      if (c > 0) @(negedge clk);
      y_ready = ($urandom_range(99) >= stall_pct);
      if (pv && !pr)
        if (!y_valid || y_data !== pd || y_sof !== ps || y_eol !== pe) stall_err++;
      pv = y_valid; pr = y_ready; pd = y_data; ps = y_sof; pe = y_eol;
      if (y_valid && y_ready) begin
        pix_q.push_back(y_data); sof_q.push_back(y_sof);
        eol_q.push_back(y_eol); cyc_q.push_back(cyc);
        if (pix_q.size() == drop_cont_at) cfg_continuous = 1'b0;
      end
    end
    timed_out = (pix_q.size() < n);
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cfg_continuous = 1'b0; y_ready = 1'b1;
    set_cfg(0, 1, 1, 0, 39);
    repeat (2) @(negedge clk);
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", y_valid); end
    n_checks++; if (y_sof !== 1'b0) begin n_fail++; $display("FAIL reset_sof got=%0b exp=0", y_sof); end
    n_checks++; if (y_eol !== 1'b0) begin n_fail++; $display("FAIL reset_eol got=%0b exp=0", y_eol); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", frame_done); end
    n_checks++; if (y_data !== 8'd16) begin n_fail++; $display("FAIL reset_data got=%0d exp=16", y_data); end
    n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
    n_checks++; if (dbg_state !== 2'(ST_IDLE)) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_start got=%0b exp=0", y_valid); end
  endtask

  // Stripes at rows 4-6 and 10-12, columns 5-24: 6*20 = 120 white
  task automatic test_basic();
    bit to;
    apply_reset();
    set_cfg(4, 3, 2, 5, 24);
    build_exp(4, 3, 2, 5, 24, 1);
    do_start();
    n_checks++; if (y_valid !== 1'b1 || y_sof !== 1'b1) begin n_fail++; $display("FAIL basic_first_beat got=v%0b s%0b exp=v1 s1", y_valid, y_sof); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%0b exp=1", busy); end
    collect(NPIX, 0, -1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout got=%0d beats exp=%0d", pix_q.size(), NPIX); end
    n_checks++; if (pix_mismatches() != 0) begin n_fail++; $display("FAIL basic_pixels got=%0d mismatches exp=0", pix_mismatches()); end
    n_checks++; if (white_count() != 120) begin n_fail++; $display("FAIL basic_white got=%0d exp=120", white_count()); end
    n_checks++; if (marker_errors() != 0) begin n_fail++; $display("FAIL basic_markers got=%0d errors exp=0", marker_errors()); end
    n_checks++; if (spacing_errors() != 0) begin n_fail++; $display("FAIL basic_spacing got=%0d errors exp=0", spacing_errors()); end
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL basic_count got=%0d exp=1", frame_count); end
    n_checks++; if (busy !== 1'b0 || y_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle got=b%0b v%0b exp=b0 v0", busy, y_valid); end
  endtask

  // 30% stalls, start held and cfg changed mid-frame: same pixels as test_basic
  task automatic test_stall();
    bit to;
    apply_reset();
    set_cfg(4, 3, 2, 5, 24);
    build_exp(4, 3, 2, 5, 24, 1);
    do_start();
    start = 1'b1;
    set_cfg(0, 1, 15, 0, 39);
    collect(NPIX, 30, -1, to);
    start = 1'b0;
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout got=%0d beats exp=%0d", pix_q.size(), NPIX); end
    n_checks++; if (pix_mismatches() != 0) begin n_fail++; $display("FAIL stall_pixels got=%0d mismatches exp=0", pix_mismatches()); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable got=%0d unstable exp=0", stall_err); end
    n_checks++; if (marker_errors() != 0) begin n_fail++; $display("FAIL stall_markers got=%0d errors exp=0", marker_errors()); end
    repeat (3) @(negedge clk);
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL stall_count got=%0d exp=1", frame_count); end
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL stall_idle got=%0b exp=0", y_valid); end
  endtask

  // Stripe 0 starts at row 27 and is cut at row 29: 3*40 = 120 white
  task automatic test_bottom();
    bit to;
    apply_reset();
    set_cfg(27, 4, 3, 0, 39);
    build_exp(27, 4, 3, 0, 39, 1);
    do_start();
    collect(NPIX, 0, -1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bottom_timeout got=%0d beats exp=%0d", pix_q.size(), NPIX); end
    n_checks++; if (pix_mismatches() != 0) begin n_fail++; $display("FAIL bottom_pixels got=%0d mismatches exp=0", pix_mismatches()); end
    n_checks++; if (white_count() != 120) begin n_fail++; $display("FAIL bottom_white got=%0d exp=120", white_count()); end
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bottom_done got=%0d exp=1", done_cnt); end
  endtask

  // stripe_h=0 handling and empty-window / zero-stripe cases
  task automatic test_degenerate();
    bit to;
    int tbl[3][6] = '{
      '{0, 0, 2, 30, 10, 0},   // x_lo > x_hi: no white
      '{2, 0, 2,  0, 39, 80},  // stripe_h 0 acts as 1: rows 2 and 4
      '{0, 2, 0,  0, 39, 0}    // zero stripes: no white
    };
    for (int t = 0; t < 3; t++) begin
      apply_reset();
      set_cfg(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], tbl[t][4]);
      build_exp(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], tbl[t][4], 1);
      do_start();
      collect(NPIX, 0, -1, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL degen%0d_timeout got=%0d beats exp=%0d", t, pix_q.size(), NPIX); end
      n_checks++; if (pix_mismatches() != 0) begin n_fail++; $display("FAIL degen%0d_pixels got=%0d mismatches exp=0", t, pix_mismatches()); end
      n_checks++; if (white_count() != tbl[t][5]) begin n_fail++; $display("FAIL degen%0d_white got=%0d exp=%0d", t, white_count(), tbl[t][5]); end
      repeat (3) @(negedge clk);
    end
  endtask

  // Three back-to-back frames; continuous dropped during frame 2
  task automatic test_back_to_back();
    bit to;
    int nsof;
    apply_reset();
    set_cfg(4, 3, 2, 5, 24);
    cfg_continuous = 1'b1;
    build_exp(4, 3, 2, 5, 24, 3);
    do_start();
    collect(3 * NPIX, 0, NPIX + 10, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout got=%0d beats exp=%0d", pix_q.size(), 3 * NPIX); end
    n_checks++; if (pix_mismatches() != 0) begin n_fail++; $display("FAIL b2b_pixels got=%0d mismatches exp=0", pix_mismatches()); end
    n_checks++; if (marker_errors() != 0) begin n_fail++; $display("FAIL b2b_markers got=%0d errors exp=0", marker_errors()); end
    n_checks++; if (spacing_errors() != 0) begin n_fail++; $display("FAIL b2b_gap got=%0d errors exp=0", spacing_errors()); end
    nsof = 0;
    foreach (sof_q[k]) if (sof_q[k]) nsof++;
    n_checks++; if (nsof != 3) begin n_fail++; $display("FAIL b2b_sof_count got=%0d exp=3", nsof); end
    repeat (4) @(negedge clk);
    n_checks++; if (done_cnt != 3) begin n_fail++; $display("FAIL b2b_done got=%0d exp=3", done_cnt); end
    n_checks++; if (frame_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", frame_count); end
    n_checks++; if (busy !== 1'b0 || y_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_stop got=b%0b v%0b exp=b0 v0", busy, y_valid); end
  endtask

  // Reset mid-frame, then confirm the next frame restarts cleanly
  task automatic test_reset_mid();
    bit to;
    apply_reset();
    set_cfg(4, 3, 2, 5, 24);
    do_start();
    collect(100, 0, -1, to);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async_valid got=%0b exp=0", y_valid); end
    n_checks++; if (busy !== 1'b0 || frame_count !== 16'd0) begin n_fail++; $display("FAIL rmid_status got=b%0b c%0d exp=b0 c0", busy, frame_count); end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (y_valid !== 1'b0 || dbg_state !== 2'(ST_IDLE)) begin n_fail++; $display("FAIL rmid_idle got=v%0b st%0d exp=v0 st0", y_valid, dbg_state); end
    build_exp(4, 3, 2, 5, 24, 1);
    do_start();
    collect(NPIX, 0, -1, to);
    n_checks++; if (to || sof_q[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_first_sof got=%0d beats exp=%0d with sof", pix_q.size(), NPIX); end
    n_checks++; if (pix_mismatches() != 0) begin n_fail++; $display("FAIL rmid_pixels got=%0d mismatches exp=0", pix_mismatches()); end
    repeat (3) @(negedge clk);
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL rmid_count got=%0d exp=1", frame_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bottom();
    test_degenerate();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
